// File: rtl/apb_gpio_ss_pkg.sv
// Shared constants for the APB GPIO subsystem: register byte offsets, register
// index enum and the debounce counter width.
package apb_gpio_ss_pkg;

  localparam int unsigned DEBOUNCE_W = 8;

  localparam logic [7:0] OFF_OUT      = 8'h00;
  localparam logic [7:0] OFF_OE       = 8'h04;
  localparam logic [7:0] OFF_IN       = 8'h08;
  localparam logic [7:0] OFF_IRQ_MASK = 8'h0C;
  localparam logic [7:0] OFF_RISE_EN  = 8'h10;
  localparam logic [7:0] OFF_FALL_EN  = 8'h14;
  localparam logic [7:0] OFF_STATUS   = 8'h18;
  localparam logic [7:0] OFF_DEBOUNCE = 8'h1C;

  typedef enum logic [2:0] {
    REG_OUT      = 3'd0,
    REG_OE       = 3'd1,
    REG_IN       = 3'd2,
    REG_IRQ_MASK = 3'd3,
    REG_RISE_EN  = 3'd4,
    REG_FALL_EN  = 3'd5,
    REG_STATUS   = 3'd6,
    REG_DEBOUNCE = 3'd7
  } reg_idx_e;

endpackage

// File: rtl/apb_gpio_ss_pin_filter.sv
// Per-pin input path: 2-flop synchroniser, optional debounce and edge detect.
// Debounce is built only when APB_GPIO_SS_DEBOUNCE_EN is defined.
module gpio_pin_filter
  import apb_gpio_ss_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  reset_int,
  input  logic                  gpi,
`ifdef APB_GPIO_SS_DEBOUNCE_EN
  input  logic [DEBOUNCE_W-1:0] debounce,
`endif
  output logic                  filtered,
  output logic                  rise,
  output logic                  fall
);

  logic sync1_q;
  logic sync2_q;
  logic delay_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser to one stage.
  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      delay_q <= 1'b0;
    end else begin
      sync1_q <= gpi;
      sync2_q <= sync1_q;
      // Tracks regardless of block enable so re-enabling never sees a stale edge.
      delay_q <= filtered;
    end
  end

`ifdef APB_GPIO_SS_DEBOUNCE_EN
  logic                  level_q;
  logic [DEBOUNCE_W-1:0] count_q;

  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      level_q <= 1'b0;
      count_q <= '0;
    end else if (sync2_q != level_q) begin
      if (count_q == debounce) begin
        level_q <= sync2_q;
        count_q <= '0;
      end else begin
        count_q <= count_q + DEBOUNCE_W'(1);
      end
    end else begin
      count_q <= '0;
    end
  end

  // A zero threshold bypasses the level register so latency matches the plain path.
  assign filtered = (debounce == '0) ? sync2_q : level_q;
`else
  assign filtered = sync2_q;
`endif

  assign rise = filtered & ~delay_q;
  assign fall = ~filtered & delay_q;

endmodule

// File: rtl/apb_gpio_ss.sv
// APB GPIO subsystem for N_PMOD 4-pin PMOD ports with edge-triggered interrupts.
// Define APB_GPIO_SS_DEBOUNCE_EN to add the DEBOUNCE register and per-pin filters.
module apb_gpio_ss
  import apb_gpio_ss_pkg::*;
#(
  parameter int APB_AW = 10,
  parameter int APB_DW = 32,
  parameter int N_PMOD = 2
) (
  input  logic                clk_in,
  input  logic                reset_int,
  input  logic [APB_AW-1:0]   PADDR,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [APB_DW-1:0]   PWDATA,
  output logic [APB_DW-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  input  logic                irq_en,
  input  logic [7:0]          ss_ctrl,
  input  logic [4*N_PMOD-1:0] pmod_gpi,
  output logic [4*N_PMOD-1:0] pmod_gpo,
  output logic [4*N_PMOD-1:0] pmod_gpio_oe,
  output logic                irq
);

  localparam int NP = 4 * N_PMOD;

  logic [NP-1:0] out_q, oe_q, mask_q, rise_en_q, fall_en_q, status_q;
  logic          irq_q;
`ifdef APB_GPIO_SS_DEBOUNCE_EN
  logic [DEBOUNCE_W-1:0] debounce_q;
`endif

  logic [NP-1:0] filt, rise, fall;
  logic [NP-1:0] set_bits, clr_bits;
  logic          block_en, access, hit, err, wr_en;
  logic [31:0]   addr_ext;
  reg_idx_e      idx;
  logic [APB_DW-1:0] rdata;

  assign block_en = ss_ctrl[0];
  assign access   = PSEL & PENABLE;
  assign addr_ext = 32'(PADDR);

  // NOTE: every always_comb output gets a default before the case, otherwise
  // unlisted addresses would hold their old value and infer a latch.
  always_comb begin
    hit = (addr_ext[31:8] == '0);
    idx = REG_OUT;
    case (addr_ext[7:0])
      OFF_OUT:      idx = REG_OUT;
      OFF_OE:       idx = REG_OE;
      OFF_IN:       idx = REG_IN;
      OFF_IRQ_MASK: idx = REG_IRQ_MASK;
      OFF_RISE_EN:  idx = REG_RISE_EN;
      OFF_FALL_EN:  idx = REG_FALL_EN;
      OFF_STATUS:   idx = REG_STATUS;
`ifdef APB_GPIO_SS_DEBOUNCE_EN
      OFF_DEBOUNCE: idx = REG_DEBOUNCE;
`else
      OFF_DEBOUNCE: hit = 1'b0;
`endif
      default:      hit = 1'b0;
    endcase
  end

  assign err      = ~hit | (PWRITE & (idx == REG_IN));
  assign wr_en    = access & PWRITE & ~err;
  assign clr_bits = (wr_en && idx == REG_STATUS) ? PWDATA[NP-1:0] : '0;
  assign set_bits = block_en ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;

  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      out_q      <= '0;
      oe_q       <= '0;
      mask_q     <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
`ifdef APB_GPIO_SS_DEBOUNCE_EN
      debounce_q <= '0;
`endif
    end else begin
      if (wr_en) begin
        case (idx)
          REG_OUT:      out_q      <= PWDATA[NP-1:0];
          REG_OE:       oe_q       <= PWDATA[NP-1:0];
          REG_IRQ_MASK: mask_q     <= PWDATA[NP-1:0];
          REG_RISE_EN:  rise_en_q  <= PWDATA[NP-1:0];
          REG_FALL_EN:  fall_en_q  <= PWDATA[NP-1:0];
`ifdef APB_GPIO_SS_DEBOUNCE_EN
          REG_DEBOUNCE: debounce_q <= PWDATA[DEBOUNCE_W-1:0];
`endif
          default: ;
        endcase
      end
      // A new edge outranks a same-cycle write-1-to-clear.
      status_q <= (status_q & ~clr_bits) | set_bits;
      irq_q    <= irq_en & block_en & (|(status_q & mask_q));
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      REG_OUT:      rdata[NP-1:0] = out_q;
      REG_OE:       rdata[NP-1:0] = oe_q;
      REG_IN:       rdata[NP-1:0] = filt;
      REG_IRQ_MASK: rdata[NP-1:0] = mask_q;
      REG_RISE_EN:  rdata[NP-1:0] = rise_en_q;
      REG_FALL_EN:  rdata[NP-1:0] = fall_en_q;
      REG_STATUS:   rdata[NP-1:0] = status_q;
`ifdef APB_GPIO_SS_DEBOUNCE_EN
      REG_DEBOUNCE: rdata[DEBOUNCE_W-1:0] = debounce_q;
`endif
      default: ;
    endcase
  end

  assign PREADY       = 1'b1;
  assign PSLVERR      = access & err & ~reset_int;
  assign PRDATA       = (access && !PWRITE && !err && !reset_int) ? rdata : '0;
  assign pmod_gpo     = block_en ? out_q : '0;
  assign pmod_gpio_oe = block_en ? oe_q : '0;
  assign irq          = irq_q;

  for (genvar i = 0; i < NP; i++) begin : g_pin
    gpio_pin_filter u_filter (
      .clk_in    (clk_in),
      .reset_int (reset_int),
      .gpi       (pmod_gpi[i]),
`ifdef APB_GPIO_SS_DEBOUNCE_EN
      .debounce  (debounce_q),
`endif
      .filtered  (filt[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

  logic unused_bits;
  assign unused_bits = ^{ss_ctrl[7:1], PWDATA};

endmodule

// File: tb/tb_apb_gpio_ss.sv
// Self-checking bench for apb_gpio_ss: register table, directed corner cases and
// randomized traffic against a pin-history reference model.
module tb_apb_gpio_ss;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NPM = 2;
  localparam int NP = 4 * NPM;

  logic          clk_in = 1'b0;
  logic          reset_int;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;
  logic          irq_en;
  logic [7:0]    ss_ctrl;
  logic [NP-1:0] pmod_gpi, pmod_gpo, pmod_gpio_oe;
  logic          irq;

  apb_gpio_ss #(.APB_AW(AW), .APB_DW(DW), .N_PMOD(NPM)) dut (
    .clk_in(clk_in), .reset_int(reset_int), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_en(irq_en), .ss_ctrl(ss_ctrl),
    .pmod_gpi(pmod_gpi), .pmod_gpo(pmod_gpo), .pmod_gpio_oe(pmod_gpio_oe), .irq(irq)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: logic sees each pin as it was two clocks ago; an edge is a
  // difference between the two- and three-clock-old samples.
  logic [NP-1:0] m_out, m_oe, m_mask, m_rise, m_fall, m_status, m_deb;
  logic          m_irq;
  logic [NP-1:0] hist [4];

  always @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      m_out = '0; m_oe = '0; m_mask = '0; m_rise = '0; m_fall = '0;
      m_status = '0; m_deb = '0; m_irq = 1'b0;
      for (int i = 0; i < 4; i++) hist[i] = '0;
    end else begin
      logic [NP-1:0] cur, prev, set_v;
      logic irq_nx;
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pmod_gpi;
      cur  = hist[2];
      prev = hist[3];
      set_v  = ss_ctrl[0] ? ((cur & ~prev & m_rise) | (~cur & prev & m_fall)) : '0;
      irq_nx = irq_en & ss_ctrl[0] & (|(m_status & m_mask));
      if (PSEL && PENABLE && PWRITE) begin
        case (PADDR)
          10'h000: m_out    = PWDATA[NP-1:0];
          10'h004: m_oe     = PWDATA[NP-1:0];
          10'h00C: m_mask   = PWDATA[NP-1:0];
          10'h010: m_rise   = PWDATA[NP-1:0];
          10'h014: m_fall   = PWDATA[NP-1:0];
          10'h018: m_status = m_status & ~PWDATA[NP-1:0];
`ifdef APB_GPIO_SS_DEBOUNCE_EN
          10'h01C: m_deb    = PWDATA[NP-1:0];
`endif
          default: ;
        endcase
      end
      m_status = m_status | set_v;
      m_irq    = irq_nx;
    end
  end

  function automatic void model_read(input logic [AW-1:0] a, output logic [31:0] d,
                                     output logic e);
    d = '0;
    e = 1'b0;
    case (a)
      10'h000: d[NP-1:0] = m_out;
      10'h004: d[NP-1:0] = m_oe;
      10'h008: d[NP-1:0] = hist[1];
      10'h00C: d[NP-1:0] = m_mask;
      10'h010: d[NP-1:0] = m_rise;
      10'h014: d[NP-1:0] = m_fall;
      10'h018: d[NP-1:0] = m_status;
`ifdef APB_GPIO_SS_DEBOUNCE_EN
      10'h01C: d[NP-1:0] = m_deb;
`endif
      default: e = 1'b1;
    endcase
  endfunction

  // Pad outputs and irq compared against the model every cycle.
  always @(negedge clk_in) begin
    #2;
    if (chk_en && !reset_int) begin
      check("gpo_cont", 32'(pmod_gpo), 32'(ss_ctrl[0] ? m_out : '0));
      check("oe_cont", 32'(pmod_gpio_oe), 32'(ss_ctrl[0] ? m_oe : '0));
      check("irq_cont", 32'(irq), 32'(m_irq));
    end
  end

  task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d, output logic e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge clk_in);
    PENABLE = 1'b1;
    #1;
    e = PSLVERR;
    check("prdata_during_write", PRDATA, 32'h0);
    @(negedge clk_in);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] d, output logic e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge clk_in);
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    e = PSLVERR;
    check("pready", 32'(PREADY), 32'h1);
    @(negedge clk_in);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          err;
    logic [31:0]   rdata;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] d, ed;
    logic e, ee;
    logic [AW-1:0] pool [10];
    pool = '{10'h000, 10'h004, 10'h008, 10'h00C, 10'h010, 10'h014, 10'h018,
             10'h020, 10'h006, 10'h3FC};

    reset_int = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    irq_en = 0; ss_ctrl = 8'h00; pmod_gpi = '0;
    #1;
    check("rst_pready", 32'(PREADY), 32'h1);
    check("rst_pslverr", 32'(PSLVERR), 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    repeat (3) @(negedge clk_in);
    reset_int = 1'b0;
    ss_ctrl = 8'h01;
    check("rst_gpo", 32'(pmod_gpo), 32'h0);
    chk_en = 1'b1;

    // Register access table, including error responses and width masking.
    tbl.push_back('{1'b1, 10'h000, 32'hFFFF_FFFF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 10'h000, 32'h0, 1'b0, 32'h0000_00FF});
    tbl.push_back('{1'b1, 10'h004, 32'h0000_005A, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 10'h004, 32'h0, 1'b0, 32'h0000_005A});
    tbl.push_back('{1'b1, 10'h008, 32'h0000_0033, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 10'h008, 32'h0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 10'h020, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 10'h005, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 10'h005, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 10'h020, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 10'h100, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 10'h000, 32'h0, 1'b0, 32'h0000_00FF});
    tbl.push_back('{1'b0, 10'h300, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 10'h00C, 32'h0000_0081, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 10'h00C, 32'h0, 1'b0, 32'h0000_0081});
    tbl.push_back('{1'b0, 10'h018, 32'h0, 1'b0, 32'h0});
`ifdef APB_GPIO_SS_DEBOUNCE_EN
    tbl.push_back('{1'b1, 10'h01C, 32'h0000_0107, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 10'h01C, 32'h0, 1'b0, 32'h0000_0007});
    tbl.push_back('{1'b1, 10'h01C, 32'h0, 1'b0, 32'h0});
`else
    tbl.push_back('{1'b1, 10'h01C, 32'h0000_0007, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 10'h01C, 32'h0, 1'b1, 32'h0});
`endif
    tbl.push_back('{1'b1, 10'h00C, 32'h0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 10'h000, 32'h0, 1'b0, 32'h0});
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        apb_write(tbl[i].addr, tbl[i].data, e);
        check($sformatf("tbl%0d_werr", i), 32'(e), 32'(tbl[i].err));
      end else begin
        apb_read(tbl[i].addr, d, e);
        check($sformatf("tbl%0d_rerr", i), 32'(e), 32'(tbl[i].err));
        check($sformatf("tbl%0d_rdata", i), d, tbl[i].rdata);
      end
    end

    // Output enable gating by the block enable.
    apb_write(10'h004, 32'hFF, e);
    apb_write(10'h000, 32'hA5, e);
    ss_ctrl = 8'h01; #1;
    check("gpo_en", 32'(pmod_gpo), 32'hA5);
    check("oe_en", 32'(pmod_gpio_oe), 32'hFF);
    ss_ctrl = 8'hFE; #1;
    check("gpo_dis", 32'(pmod_gpo), 32'h0);
    check("oe_dis", 32'(pmod_gpio_oe), 32'h0);
    @(negedge clk_in);
    apb_read(10'h000, d, e);
    check("out_kept", d, 32'hA5);
    ss_ctrl = 8'h01;

    // Rising edge on pin 0: STATUS three clocks later, irq one clock after that.
    apb_write(10'h010, 32'h01, e);
    apb_write(10'h00C, 32'h01, e);
    apb_write(10'h018, 32'hFF, e);
    irq_en = 1'b1;
    pmod_gpi[0] = 1'b1;
    apb_read(10'h008, d, e);
    check("in_after1", d, 32'h0);
    @(negedge clk_in); #1;
    check("irq_before", 32'(irq), 32'h0);
    @(negedge clk_in); #1;
    check("irq_set", 32'(irq), 32'h1);
    apb_read(10'h018, d, e);
    check("status_set", d, 32'h01);
    apb_read(10'h008, d, e);
    check("in_high", d, 32'h01);
    apb_write(10'h018, 32'h01, e);
    @(negedge clk_in); #1;
    check("irq_cleared", 32'(irq), 32'h0);

    // Edge and write-1-to-clear on the same clock: the edge wins.
    pmod_gpi[0] = 1'b0;
    repeat (5) @(negedge clk_in);
    pmod_gpi[0] = 1'b1;
    @(negedge clk_in);
    apb_write(10'h018, 32'h01, e);
    apb_read(10'h018, d, e);
    check("set_wins", d, 32'h01);

    // Edge while disabled must not appear once the block is re-enabled.
    apb_write(10'h010, 32'h05, e);
    apb_write(10'h00C, 32'h05, e);
    apb_write(10'h018, 32'hFF, e);
    ss_ctrl = 8'h00;
    pmod_gpi[2] = 1'b1;
    repeat (5) @(negedge clk_in);
    ss_ctrl = 8'h01;
    repeat (4) @(negedge clk_in);
    apb_read(10'h018, d, e);
    check("no_spurious", d, 32'h0);
    pmod_gpi[2] = 1'b0;
    repeat (5) @(negedge clk_in);
    pmod_gpi[2] = 1'b1;
    repeat (6) @(negedge clk_in);
    #1;
    check("irq_pin2", 32'(irq), 32'h1);

    // Reset during the access phase of a write to OUT.
    apb_write(10'h000, 32'h0F, e);
    chk_en = 1'b0;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 10'h000; PWDATA = 32'h3C;
    @(negedge clk_in);
    PENABLE = 1'b1;
    #2 reset_int = 1'b1;
    #1;
    check("rst_async_gpo", 32'(pmod_gpo), 32'h0);
    check("rst_async_irq", 32'(irq), 32'h0);
    check("rst_async_pslverr", 32'(PSLVERR), 32'h0);
    @(negedge clk_in);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge clk_in);
    reset_int = 1'b0;
    chk_en = 1'b1;
    apb_read(10'h000, d, e);
    check("rst_out", d, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: begin
          logic [AW-1:0] a;
          a = pool[$urandom_range(0, 9)];
          apb_write(a, $urandom, e);
          ee = !(a inside {10'h000, 10'h004, 10'h00C, 10'h010, 10'h014, 10'h018});
          check("rnd_werr", 32'(e), 32'(ee));
        end
        1: begin
          logic [AW-1:0] a;
          a = pool[$urandom_range(0, 9)];
          apb_read(a, d, e);
          model_read(a, ed, ee);
          check("rnd_rerr", 32'(e), 32'(ee));
          check("rnd_rdata", d, ee ? 32'h0 : ed);
        end
        2: begin
          pmod_gpi = NP'($urandom);
          @(negedge clk_in);
        end
        3: begin
          ss_ctrl = 8'($urandom_range(0, 3));
          irq_en = 1'($urandom);
          @(negedge clk_in);
        end
        default: repeat ($urandom_range(1, 4)) @(negedge clk_in);
      endcase
    end

`ifdef APB_GPIO_SS_DEBOUNCE_EN
    // Debounce threshold 3: a 3-cycle glitch is ignored, a 6-cycle pulse lands
    // on the sixth clock.
    chk_en = 1'b0;
    pmod_gpi = '0;
    repeat (6) @(negedge clk_in);
    apb_write(10'h01C, 32'h3, e);
    pmod_gpi[1] = 1'b1;
    repeat (3) @(negedge clk_in);
    pmod_gpi[1] = 1'b0;
    @(negedge clk_in);
    apb_read(10'h008, d, e);
    check("deb_glitch", d & 32'h2, 32'h0);
    repeat (10) @(negedge clk_in);
    pmod_gpi[1] = 1'b1;
    repeat (4) @(negedge clk_in);
    apb_read(10'h008, d, e);
    check("deb_early", d & 32'h2, 32'h0);
    repeat (6) @(negedge clk_in);
    pmod_gpi[1] = 1'b0;
    repeat (12) @(negedge clk_in);
    pmod_gpi[1] = 1'b1;
    repeat (5) @(negedge clk_in);
    apb_read(10'h008, d, e);
    check("deb_land", d & 32'h2, 32'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_gpio_ss.md
APB_GPIO_SS -- requirements
Module: apb_gpio_ss

Interface
REQ-001 Parameter APB_AW, default 10, APB address width.
REQ-002 Parameter APB_DW, default 32, APB data width.
REQ-003 Parameter N_PMOD, default 2, range 1..8, number of 4-pin PMOD ports; total pins NP = 4*N_PMOD.
REQ-004 clk_in  input  1  sole clock; all state on rising edge.
REQ-005 reset_int  input  1  reset, asynchronous, active-high.
REQ-006 PADDR/PSEL/PENABLE/PWRITE/PWDATA  input  APB_AW/1/1/1/APB_DW  APB slave request.
REQ-007 PRDATA/PREADY/PSLVERR  output  APB_DW/1/1  APB slave response.
REQ-008 irq_en  input  1  global interrupt enable.
REQ-009 ss_ctrl  input  8  subsystem control; bit0 = block enable, bits 7:1 ignored.
REQ-010 pmod_gpi  input  NP  pad inputs, pin 4*p+k = PMOD p, pin k.
REQ-011 pmod_gpo  output  NP  pad output values.
REQ-012 pmod_gpio_oe  output  NP  pad output enables, 1 = drive.
REQ-013 irq  output  1  level interrupt.

Function
REQ-014 Register map (byte offsets): 0x00 OUT rw, 0x04 OE rw, 0x08 IN ro, 0x0C IRQ_MASK rw, 0x10 RISE_EN rw, 0x14 FALL_EN rw, 0x18 STATUS w1c, 0x1C DEBOUNCE rw (macro only).
REQ-015 Register width NP; bits NP..APB_DW-1 read 0, writes ignored.
REQ-016 PREADY SHALL be constant 1; zero wait states.
REQ-017 Write commits on the clock edge where PSEL&PENABLE&PWRITE; read data valid combinationally while PSEL&PENABLE&!PWRITE.
REQ-018 PSLVERR=1 during access phase for unmapped offsets, unaligned PADDR[1:0]!=0, or write to IN; erroneous writes change no state; erroneous reads return 0.
REQ-019 PRDATA SHALL be 0 outside a read access phase.
REQ-020 Each pmod_gpi bit passes through a 2-flop synchroniser; IN reflects filtered value; IN latency = 2 cycles (DEBOUNCE=0).
REQ-021 Edge detect compares filtered value to its 1-cycle-delayed copy; rise sets STATUS[i] if RISE_EN[i], fall sets STATUS[i] if FALL_EN[i].
REQ-022 STATUS write-1-to-clear; same-cycle set and clear on one bit: set wins.
REQ-023 irq = irq_en & ss_ctrl[0] & |(STATUS & IRQ_MASK), registered (1 cycle after STATUS update).
REQ-024 ss_ctrl[0]=0: pmod_gpo and pmod_gpio_oe forced 0, STATUS not set, registers remain APB-accessible.
REQ-025 ss_ctrl[0]=1: pmod_gpo = OUT, pmod_gpio_oe = OE, combinationally from registers.
REQ-026 ss_ctrl[0] 0->1 SHALL NOT produce a spurious edge: delayed copy tracks filtered value while disabled.

Reset
REQ-027 On reset_int all registers, synchronisers, delayed copies and irq reset to 0 immediately; PRDATA=0, PSLVERR=0, PREADY=1.
REQ-028 Reset asserted mid-transfer aborts it; no partial write persists.

Configuration
REQ-029 Macro APB_GPIO_SS_DEBOUNCE_EN defined: DEBOUNCE[7:0] register present; per pin, filtered value updates only after synchronised input differs from it for DEBOUNCE+1 consecutive cycles; counter resets on any return to filtered value; DEBOUNCE=0 is pass-through.
REQ-030 Macro undefined: no counters, filtered = synchronised; 0x1C unmapped (PSLVERR, reads 0).

Structure
REQ-031 Package apb_gpio_ss_pkg holds register offset constants, register index enum, DEBOUNCE width constant.
REQ-032 Sub-module gpio_pin_filter (synchroniser, optional debounce, edge detect) instantiated NP times via generate.

Verification
REQ-033 Write OE=0xFF, OUT=0xA5, ss_ctrl=0x01 -> pmod_gpo=0xA5, pmod_gpio_oe=0xFF; ss_ctrl=0x00 -> both 0, OUT still reads 0xA5.
REQ-034 RISE_EN=0x01, IRQ_MASK=0x01, irq_en=1, pmod_gpi[0] 0->1 -> STATUS=0x01 after 3 cycles, irq=1 cycle after; write STATUS=0x01 -> irq=0.
REQ-035 Edge on pin 0 in same cycle as STATUS w1c of bit 0 -> STATUS[0] remains 1.
REQ-036 Read 0x20, write 0x08, PADDR=0x05 -> PSLVERR=1, PRDATA=0, no register change.
REQ-037 With macro, DEBOUNCE=3: 3-cycle glitch on pin 1 -> IN unchanged; 6-cycle pulse -> IN[1]=1 after 2+4 cycles.
REQ-038 reset_int asserted mid-write to OUT -> OUT=0, irq=0 asynchronously, before next clock edge.
